// File: rtl/ball_drop_sequencer.sv
// Purpose : game-level sequencer for the falling-ball datapath (serve, fall, catch/miss, score, lives, game over).
// Latency : fall_en is combinational off the registered state (0 cycles from frame_tick); all other outputs are registered, 1 cycle.
// Backpressure: none; frame_tick and start_btn are sampled every cycle, and ticks arriving in JUDGE/MISS are dropped.
//
// Ports:
//   clk_in, reset           clock and synchronous active-high reset
//   frame_tick              one-cycle pulse per video frame
//   start_btn               debounced start level; its rising edge starts a game from IDLE or OVER
//   ball_x, ball_y, radius  ball geometry from the random-ball generator
//   bar_x                   bar centre X from the bar logic
//   new_game, caught        one-cycle strobes to the generator (never both high)
//   fall_en, fall_step      per-frame advance strobe and pixels per step
//   score, lives, game_over game status for the HUD
//   state_o                 FSM encoding: IDLE=0 SERVE=1 FALL=2 JUDGE=3 MISS=4 OVER=5
//
// Build option: define SPEEDUP_EN to raise fall_step by one on every 8th catch, saturating at 7.
// Without it, fall_step is tied to 1 and no step register exists.

module ball_drop_sequencer #(
    parameter int unsigned BAR_Y        = 440,
    parameter int unsigned BAR_HALF_W   = 40,
    parameter int unsigned BOTTOM_Y     = 457,
    parameter int unsigned LIVES_INIT   = 3,
    parameter int unsigned SERVE_FRAMES = 30,
    parameter int unsigned SCORE_W      = 10
) (
    input  logic               clk_in,
    input  logic               reset,
    input  logic               frame_tick,
    input  logic               start_btn,
    input  logic [9:0]         ball_x,
    input  logic [9:0]         ball_y,
    input  logic [10:0]        radius,
    input  logic [9:0]         bar_x,
    output logic               new_game,
    output logic               caught,
    output logic               fall_en,
    output logic [2:0]         fall_step,
    output logic [SCORE_W-1:0] score,
    output logic [1:0]         lives,
    output logic               game_over,
    output logic [2:0]         state_o
);

    localparam int unsigned CNT_W = $clog2(SERVE_FRAMES + 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_SERVE = 3'd1,
        S_FALL  = 3'd2,
        S_JUDGE = 3'd3,
        S_MISS  = 3'd4,
        S_OVER  = 3'd5
    } state_t;

    state_t             state_q;
    logic               start_q;
    logic               new_game_q;
    logic               caught_q;
    logic               game_over_q;
    logic [SCORE_W-1:0] score_q;
    logic [SCORE_W-1:0] score_d;
    logic [1:0]         lives_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [10:0] bottom;
    logic [10:0] left_reach;
    logic [10:0] right_reach;
    logic        hit_x;
    logic        at_bar;
    logic        past_bottom;
    logic        start_rise;

    // Judging geometry. Everything is 11-bit unsigned, so ball_y + radius
    // deliberately wraps rather than growing a carry bit.
    always_comb begin
        bottom      = {1'b0, ball_y} + radius;
        left_reach  = {1'b0, ball_x} + 11'(BAR_HALF_W);
        right_reach = {1'b0, bar_x}  + 11'(BAR_HALF_W);
        hit_x       = (left_reach >= {1'b0, bar_x}) && ({1'b0, ball_x} <= right_reach);
        at_bar      = (bottom >= 11'(BAR_Y));
        past_bottom = ({1'b0, ball_y} >= 11'(BOTTOM_Y));
    end

    assign start_rise = start_btn & ~start_q;

    // Saturating score increment: an all-ones score stays put.
    assign score_d = (score_q == '1) ? score_q : score_q + SCORE_W'(1);

    // Same-cycle gate so the ball moves on the frame it is told to.
    assign fall_en = (state_q == S_FALL) && frame_tick;

`ifdef SPEEDUP_EN
    logic [2:0] step_q;
    assign fall_step = step_q;
`else
    assign fall_step = 3'd1;
`endif

    always_ff @(posedge clk_in) begin
        if (reset) begin
            state_q     <= S_IDLE;
            // Capture the live button so a button held through reset does not start a game.
            start_q     <= start_btn;
            new_game_q  <= 1'b0;
            caught_q    <= 1'b0;
            game_over_q <= 1'b0;
            score_q     <= '0;
            lives_q     <= '0;
            cnt_q       <= '0;
`ifdef SPEEDUP_EN
            step_q      <= 3'd1;
`endif
        end else begin
            start_q    <= start_btn;
            new_game_q <= 1'b0;
            caught_q   <= 1'b0;

            case (state_q)
                S_IDLE, S_OVER: begin
                    if (start_rise) begin
                        new_game_q  <= 1'b1;
                        lives_q     <= 2'(LIVES_INIT);
                        score_q     <= '0;
                        game_over_q <= 1'b0;
                        cnt_q       <= '0;
                        state_q     <= S_SERVE;
`ifdef SPEEDUP_EN
                        step_q      <= 3'd1;
`endif
                    end
                end

                S_SERVE: begin
                    if (frame_tick) begin
                        if (cnt_q == CNT_W'(SERVE_FRAMES - 1)) begin
                            cnt_q   <= '0;
                            state_q <= S_FALL;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                end

                S_FALL: begin
                    // A catch takes priority over a miss in the same cycle.
                    // caught is raised on entry so it is high exactly while in JUDGE.
                    if (at_bar && hit_x) begin
                        caught_q <= 1'b1;
                        state_q  <= S_JUDGE;
                    end else if (past_bottom) begin
                        state_q <= S_MISS;
                    end
                end

                S_JUDGE: begin
                    score_q <= score_d;
`ifdef SPEEDUP_EN
                    // Speed up only on a real increment that lands on a multiple of 8.
                    if ((score_q != '1) && (score_d[2:0] == 3'b000) && (step_q != 3'd7)) begin
                        step_q <= step_q + 3'd1;
                    end
`endif
                    cnt_q   <= '0;
                    state_q <= S_SERVE;
                end

                S_MISS: begin
                    if (lives_q <= 2'd1) begin
                        lives_q     <= '0;
                        game_over_q <= 1'b1;
                        state_q     <= S_OVER;
                    end else begin
                        lives_q <= lives_q - 2'd1;
                        cnt_q   <= '0;
                        state_q <= S_SERVE;
                    end
                end

                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign new_game  = new_game_q;
    assign caught    = caught_q;
    assign game_over = game_over_q;
    assign score     = score_q;
    assign lives     = lives_q;
    assign state_o   = state_q;

endmodule
